// File: rtl/tt_counter_pkg.sv
// Shared constants and helpers for the 8-bit programmable counter tile.
// Holds ui_in bit positions, state widths and the saturating/wrapping step.
// Pure declarations; no state lives here.
package tt_counter_pkg;

    localparam int COUNT_W = 8;
    localparam int PRE_W   = 7;
    localparam int PS_W    = 3;

    // Bit positions of the control fields inside ui_in
    localparam int CNT_EN  = 0;
    localparam int DIR     = 1;
    localparam int LOAD    = 2;
    localparam int CLEAR   = 3;
    localparam int SAT     = 4;
    localparam int PS_LSB  = 5;

    typedef struct packed {
        logic            cnt_en;
        logic            dir;
        logic            load;
        logic            clear;
        logic            sat;
        logic [PS_W-1:0] ps_sel;
    } ctrl_t;

    // Split the raw control byte into named fields
    function automatic ctrl_t decode_ctrl(input logic [7:0] ui);
        ctrl_t c;
        c.cnt_en = ui[CNT_EN];
        c.dir    = ui[DIR];
        c.load   = ui[LOAD];
        c.clear  = ui[CLEAR];
        c.sat    = ui[SAT];
        c.ps_sel = ui[PS_LSB +: PS_W];
        return c;
    endfunction

    // One count step; saturation looks at the value before the step
    function automatic logic [COUNT_W-1:0] step_count(
        input logic [COUNT_W-1:0] cur,
        input logic               up,
        input logic               sat
    );
        logic [COUNT_W-1:0] nxt;
        if (up) begin
            nxt = (sat && (cur == {COUNT_W{1'b1}})) ? cur : cur + 1'b1;
        end else begin
            nxt = (sat && (cur == '0)) ? cur : cur - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tt_um_8b_counter_ajamous1_prescaler.sv
// Power-of-two prescaler: free-running 7-bit pre counter, tick on low-bit all-ones.
// Tick is combinational from the current pre value (same cycle as the enabled step).
// No backpressure; ena low freezes pre, restart zeroes it.
module counter_prescaler
    import tt_counter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            inc,
    input  logic            restart,
    input  logic [PS_W-1:0] ps_sel,
    output logic            tick
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [PRE_W-1:0] mask;

    // Mask of the low ps_sel bits; ps_sel=0 yields an empty mask (tick every cycle)
    always_comb begin
        mask = PRE_W'((8'd1 << ps_sel) - 8'd1);
        tick = ena & inc & ~restart & ((pre_q & mask) == mask);
    end

    // Next prescaler value: restart beats increment, ena low holds
    always_comb begin
        pre_d = pre_q;
        if (ena) begin
            if (restart) begin
                pre_d = '0;
            end else if (inc) begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Prescaler register; rst_n is an active-high asynchronous reset
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/tt_um_8b_counter_ajamous1.sv
// Tiny Tapeout tile: 8-bit up/down counter with load, clear, saturate and prescaler.
// One cycle from control inputs to uo_out; reset clears uo_out immediately.
// No backpressure; ena low or cnt_en low holds all state.
module tt_um_8b_counter_ajamous1
    import tt_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    ctrl_t              ctrl;
    logic               tick;
    logic               restart;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Decode controls; clear and load both restart the prescaler phase
    always_comb begin
        ctrl    = decode_ctrl(ui_in);
        restart = ctrl.clear | ctrl.load;
    end

    counter_prescaler u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .inc     (ctrl.cnt_en),
        .restart (restart),
        .ps_sel  (ctrl.ps_sel),
        .tick    (tick)
    );

    // Priority: clear > load > prescaled step > hold
    always_comb begin
        count_d = count_q;
        if (ena) begin
            if (ctrl.clear) begin
                count_d = '0;
            end else if (ctrl.load) begin
                count_d = uio_in;
            end else if (tick) begin
                count_d = step_count(count_q, ctrl.dir, ctrl.sat);
            end
        end
    end

    // Count register; rst_n is an active-high asynchronous reset
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign uo_out  = count_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_8b_counter_ajamous1.sv
// Self-checking bench for the counter tile: scoreboard of expected counts plus directed checks.
module tb_tt_um_8b_counter_ajamous1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    int m_cnt = 0;
    int m_pre = 0;
    logic [7:0] exp_q[$];

    tt_um_8b_counter_ajamous1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ctl(input bit en, input bit dir, input bit ld, input bit clr,
                           input bit sat, input bit [2:0] ps);
        ui_in = {ps, sat, clr, ld, dir, en};
    endtask

    // Behavioural model of one rising edge, written from the counter's description
    task automatic model_edge();
        int ps;
        if (rst_n) begin
            m_cnt = 0;
            m_pre = 0;
        end else if (ena) begin
            if (ui_in[3]) begin
                m_cnt = 0;
                m_pre = 0;
            end else if (ui_in[2]) begin
                m_cnt = int'(uio_in);
                m_pre = 0;
            end else if (ui_in[0]) begin
                ps = int'(ui_in[7:5]);
                if (((m_pre + 1) % (1 << ps)) == 0) begin
                    if (ui_in[1]) m_cnt = (ui_in[4] && m_cnt == 255) ? 255 : (m_cnt + 1) % 256;
                    else          m_cnt = (ui_in[4] && m_cnt == 0)   ? 0   : (m_cnt + 255) % 256;
                end
                m_pre = (m_pre + 1) % 128;
            end
        end
    endtask

    // Push the expected result, take one edge, then compare away from the edge
    task automatic cycle();
        model_edge();
        exp_q.push_back(8'(m_cnt));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            chk("uo_out", uo_out, exp_q.pop_front());
        end
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            chk("uio_out", uio_out, 8'h00);
            chk("uio_oe", uio_oe, 8'h00);
        end
    endtask

    task automatic load_val(input logic [7:0] v);
        uio_in = v;
        set_ctl(0, 0, 1, 0, 0, 0);
        cycle();
    endtask

    logic [7:0] up_nosat[3]  = '{8'hFF, 8'h00, 8'h01};
    logic [7:0] up_sat[3]    = '{8'hFF, 8'hFF, 8'hFF};
    logic [7:0] dn_nosat[2]  = '{8'h00, 8'hFF};
    logic [7:0] dn_sat[2]    = '{8'h00, 8'h00};

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        uio_in = 8'h00;
        set_ctl(0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Basic count up, ps_sel=0
        set_ctl(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        chk("count5", uo_out, 8'h05);

        // Asynchronous reset in the middle of a run
        cycle();
        #2;
        rst_n = 1'b1;
        #1;
        chk("async_reset", uo_out, 8'h00);
        m_cnt = 0;
        m_pre = 0;
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("after_reset_step", uo_out, 8'h01);

        // Wrap and saturate, up
        load_val(8'hFE);
        set_ctl(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin cycle(); chk("wrap_up", uo_out, up_nosat[i]); end
        load_val(8'hFE);
        set_ctl(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin cycle(); chk("sat_up", uo_out, up_sat[i]); end

        // Wrap and saturate, down
        load_val(8'h01);
        set_ctl(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin cycle(); chk("wrap_dn", uo_out, dn_nosat[i]); end
        load_val(8'h01);
        set_ctl(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin cycle(); chk("sat_dn", uo_out, dn_sat[i]); end

        // Prescaler ps_sel=3: steps on enabled edges 8, 16, 24
        set_ctl(0, 1, 0, 1, 0, 3);
        cycle();
        set_ctl(1, 1, 0, 0, 0, 3);
        for (int i = 1; i <= 24; i++) begin
            cycle();
            chk("ps3_edge", uo_out, 8'(i / 8));
        end

        // Priority: clear over load, load over a tick
        uio_in = 8'h5A;
        set_ctl(1, 1, 1, 1, 0, 0);
        cycle();
        chk("clear_over_load", uo_out, 8'h00);
        set_ctl(1, 1, 1, 0, 0, 0);
        cycle();
        chk("load_over_tick", uo_out, 8'h5A);
        set_ctl(1, 1, 0, 0, 0, 0);
        cycle();
        chk("step_after_load", uo_out, 8'h5B);

        // Hold with ena low, then with cnt_en low
        load_val(8'h10);
        ena = 1'b0;
        set_ctl(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle();
        chk("hold_ena", uo_out, 8'h10);
        ena = 1'b1;
        set_ctl(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("hold_cnt_en", uo_out, 8'h10);

        // Direction change takes effect on the next edge
        set_ctl(0, 1, 0, 1, 0, 0);
        cycle();
        set_ctl(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("dir_up3", uo_out, 8'h03);
        set_ctl(1, 0, 0, 0, 0, 0);
        cycle();
        chk("dir_dn1", uo_out, 8'h02);
        cycle();
        chk("dir_dn2", uo_out, 8'h01);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ena    = ($urandom_range(0, 9) != 0);
            uio_in = 8'($urandom);
            set_ctl($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
                    $urandom_range(0, 39) == 0, 1'($urandom), 3'($urandom_range(0, 3)));
            cycle();
        end

        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
